// File: rtl/if_id_buffer.sv
// if_id_buffer: fetch-to-decode pipeline register with a 2-entry skid buffer
module if_id_buffer #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] NOP_INST = '0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_inst,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_next_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_inst,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_next_pc,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] main_inst, skid_inst, skid_pc, skid_npc;
  logic acc, pop, load_in, load_skid, shift;
  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign out_valid = state != EMPTY;
  assign out_inst = out_valid ? main_inst : NOP_INST;
  always_comb begin
    state_n = state;
    load_in = 1'b0;
    load_skid = 1'b0;
    shift = 1'b0;
    if (flush) state_n = EMPTY;
    else
      case (state)
        EMPTY: if (acc) begin state_n = ONE; load_in = 1'b1; end
        ONE: begin
          load_in = acc & pop;
          load_skid = acc & ~pop;
          state_n = acc ? (pop ? ONE : TWO) : (pop ? EMPTY : ONE);
        end
        TWO: if (pop) begin state_n = ONE; shift = 1'b1; end
        default: state_n = EMPTY;
      endcase
  end
  // in_ready comes from next state so it is a plain flop, never a path from out_ready
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state <= state_n;
      in_ready <= state_n != TWO;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      main_inst <= NOP_INST;
      out_pc <= '0;
      out_next_pc <= '0;
      skid_inst <= '0;
      skid_pc <= '0;
      skid_npc <= '0;
    end else begin
      if (load_in) begin
        main_inst <= in_inst;
        out_pc <= in_pc;
        out_next_pc <= in_next_pc;
      end else if (shift) begin
        main_inst <= skid_inst;
        out_pc <= skid_pc;
        out_next_pc <= skid_npc;
      end
      if (flush) begin
        skid_inst <= '0;
        skid_pc <= '0;
        skid_npc <= '0;
      end else if (load_skid) begin
        skid_inst <= in_inst;
        skid_pc <= in_pc;
        skid_npc <= in_next_pc;
      end
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) stall_cnt <= '0;
    else if (out_valid && !out_ready && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: random handshake bench against a queue-based reference model
module tb_if_id_buffer;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam int SAT = 15;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
  } word_t;
  logic clk = 0, rst = 0;
  logic in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 0;
  logic [31:0] in_inst = 0, in_pc = 0, in_next_pc = 0, out_inst, out_pc, out_next_pc;
  logic [3:0] stall_cnt;
  int n_chk = 0, n_err = 0, n_acc = 0;
  word_t q[$];
  logic m_ready = 1;
  logic [31:0] last_pc = 0, last_npc = 0, pc_m = 0;
  int m_stall = 0;
  if_id_buffer #(.WIDTH(32), .NOP_INST(NOP), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .in_next_pc(in_next_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .out_next_pc(out_next_pc),
    .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(m_ready));
    chk({tag, ".out_inst"}, 64'(out_inst), 64'(q.size() > 0 ? q[0].inst : NOP));
    chk({tag, ".out_pc"}, 64'(out_pc), 64'(last_pc));
    chk({tag, ".out_next_pc"}, 64'(out_next_pc), 64'(last_npc));
    chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
  endtask
  task automatic model_reset();
    q.delete();
    m_ready = 1;
    last_pc = 0;
    last_npc = 0;
    m_stall = 0;
  endtask
  task automatic cycle(input string tag, input logic v, input logic rdy, input logic fl);
    word_t w;
    logic acc, pop;
    w.inst = $urandom;
    w.pc = pc_m;
    w.npc = pc_m + 4;
    in_valid = v;
    in_inst = w.inst;
    in_pc = w.pc;
    in_next_pc = w.npc;
    out_ready = rdy;
    flush = fl;
    acc = v && m_ready;
    pop = q.size() > 0 && rdy;
    if (q.size() > 0 && !rdy && !fl && m_stall < SAT) m_stall++;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back(w);
        pc_m += 4;
        n_acc++;
      end
    end
    m_ready = q.size() < 2;
    if (q.size() > 0) begin
      last_pc = q[0].pc;
      last_npc = q[0].npc;
    end
    #1;
    check_all(tag);
  endtask
  initial begin
    int target, guard;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) cycle("stream", 1, 1, 0);
    cycle("stream_drain", 0, 1, 0);
    chk("stream_no_stall", 64'(stall_cnt), 64'd0);
    cycle("skid", 1, 0, 0);
    cycle("skid", 1, 0, 0);
    chk("skid_full", 64'(in_ready), 64'd0);
    cycle("skid_pop1", 0, 1, 0);
    chk("skid_first", 64'(out_pc), 64'h14);
    cycle("skid_pop2", 0, 1, 0);
    pc_m = 32'h38;
    cycle("hold", 1, 0, 0);
    cycle("hold", 1, 0, 0);
    pc_m = 32'h40;
    cycle("flush", 1, 1, 1);
    chk("flush_empty", 64'(out_valid), 64'd0);
    cycle("after_flush", 0, 1, 0);
    chk("flush_drop", 64'(out_pc == 32'h40), 64'd0);
    cycle("sat_load", 1, 0, 0);
    for (int i = 0; i < 20; i++) cycle("sat", 0, 0, 0);
    chk("sat_value", 64'(stall_cnt), 64'd15);
    cycle("mid_load", 1, 0, 0);
    #2 rst = 0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    target = n_acc + 1000;
    guard = 0;
    while (n_acc < target && guard < 20000) begin
      cycle("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
      guard++;
    end
    chk("rand_budget", 64'(n_acc >= target), 64'd1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
